// File: rtl/bank_grant_encoder8_pkg.sv
// Shared constants, FSM encoding and one-hot decode helper for the bank grant encoder.
// The RAM16K read side uses the same helper.
package bank_grant_encoder8_pkg;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++)
      if (oh[i]) idx |= IDX_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/bank_grant_encoder8_rr_pick8.sv
// Circular priority search: first requester after 'last' (wrapping) that is not excluded.
module rr_pick8
  import bank_grant_encoder8_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic [N-1:0]     excl,
  output logic             found,
  output logic [IDX_W-1:0] winner,
  output logic [N-1:0]     winner_oh
);
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] idx;

  assign cand = req & ~excl;

  always_comb begin
    found     = 1'b0;
    winner_oh = '0;
    idx       = '0;
    // k = N lands back on 'last' itself, so it is searched last
    for (int k = 1; k <= N; k++) begin
      idx = last + IDX_W'(k);
      if (!found && cand[idx]) begin
        found          = 1'b1;
        winner_oh[idx] = 1'b1;
      end
    end
    winner = onehot_to_idx(winner_oh);
  end
endmodule

// File: rtl/bank_grant_encoder8.sv
// 8-way round-robin bank arbiter with registered one-hot grant, binary index
// and optional max-hold preemption.
module bank_grant_encoder8
  import bank_grant_encoder8_pkg::*;
#(
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);
  localparam logic [7:0] HOLD_LIM = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_e           state, state_nxt;
  logic [IDX_W-1:0] last, last_nxt, gnt_idx_nxt, pick_last;
  logic [N-1:0]     gnt_nxt, pick_excl, win_oh;
  logic [7:0]       hold_cnt, hold_cnt_nxt;
  logic             gnt_valid_nxt, preempt_nxt, found, lim_hit;
  logic [IDX_W-1:0] win;

  // While busy the search restarts after the holder and never returns to it
  assign pick_last = (state == BUSY) ? gnt_idx : last;
  assign pick_excl = (state == BUSY) ? gnt : '0;
  assign lim_hit   = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM);

  rr_pick8 u_pick (
    .req       (req),
    .last      (pick_last),
    .excl      (pick_excl),
    .found     (found),
    .winner    (win),
    .winner_oh (win_oh)
  );

  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    gnt_nxt       = gnt;
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = gnt_valid;
    hold_cnt_nxt  = hold_cnt;
    preempt_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt       = win_oh;
          gnt_idx_nxt   = win;
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = '0;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (!req[gnt_idx]) begin
          last_nxt     = gnt_idx;
          hold_cnt_nxt = '0;
          if (found) begin
            gnt_nxt     = win_oh;
            gnt_idx_nxt = win;
          end else begin
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
            state_nxt     = IDLE;
          end
        end else if (lim_hit && found) begin
          last_nxt     = gnt_idx;
          gnt_nxt      = win_oh;
          gnt_idx_nxt  = win;
          hold_cnt_nxt = '0;
          preempt_nxt  = 1'b1;
        end else if (hold_cnt != 8'hFF) begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDX_W'(N - 1);
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
      hold_cnt  <= hold_cnt_nxt;
      preempt   <= preempt_nxt;
    end
  end
endmodule

// File: tb/tb_bank_grant_encoder8.sv
// Directed + random bench for bank_grant_encoder8 (MAX_HOLD=0 and MAX_HOLD=4 instances).
module tb_bank_grant_encoder8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt0, gnt4;
  logic [2:0] idx0, idx4;
  logic       vld0, vld4, pre0, pre4;

  int n_assert = 0;
  int n_fail   = 0;

  // reference state per instance: holder -1 means idle
  int m_hold[2], m_idx[2], m_last[2], m_cnt[2], m_pre[2];
  int mh[2] = '{0, 4};

  always #5 clk = ~clk;

  bank_grant_encoder8 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0), .preempt(pre0)
  );
  bank_grant_encoder8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4), .preempt(pre4)
  );

  function automatic int search(input logic [7:0] r, input int from, input int excl);
    int i;
    for (int k = 1; k <= 8; k++) begin
      i = (from + k) % 8;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int m);
    int h, w;
    if (!rst_n) begin
      m_hold[m] = -1; m_idx[m] = 0; m_last[m] = 7; m_cnt[m] = 0; m_pre[m] = 0;
      return;
    end
    m_pre[m] = 0;
    h = m_hold[m];
    if (h < 0) begin
      w = search(req, m_last[m], -1);
      if (w >= 0) begin m_hold[m] = w; m_idx[m] = w; m_cnt[m] = 0; end
    end else if (!req[h]) begin
      m_last[m] = h;
      m_cnt[m]  = 0;
      w = search(req, h, h);
      m_hold[m] = w;
      if (w >= 0) m_idx[m] = w;
    end else if (mh[m] != 0 && m_cnt[m] >= mh[m] - 1 && search(req, h, h) >= 0) begin
      w = search(req, h, h);
      m_last[m] = h; m_hold[m] = w; m_idx[m] = w; m_cnt[m] = 0; m_pre[m] = 1;
    end else if (m_cnt[m] < 255) begin
      m_cnt[m]++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    logic [7:0] eg;
    for (int m = 0; m < 2; m++) begin
      eg = (m_hold[m] < 0) ? 8'h00 : (8'h01 << m_hold[m]);
      chk(m ? "m4.gnt" : "m0.gnt", m ? gnt4 : gnt0, eg);
      chk(m ? "m4.idx" : "m0.idx", 8'(m ? idx4 : idx0), 8'(m_idx[m]));
      chk(m ? "m4.vld" : "m0.vld", 8'(m ? vld4 : vld0), 8'(m_hold[m] >= 0));
      chk(m ? "m4.pre" : "m0.pre", 8'(m ? pre4 : pre0), 8'(m_pre[m]));
      chk(m ? "m4.oh0" : "m0.oh0", 8'($onehot0(m ? gnt4 : gnt0)), 8'd1);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 8'h00;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00;
    cyc(); cyc();
    chk("rst.gnt", gnt0, 8'h00);
    chk("rst.idx", 8'(idx0), 8'h00);
    chk("rst.vld", 8'(vld0), 8'h00);
    chk("rst.pre", 8'(pre4), 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle.gnt", gnt0, 8'h00);
      chk("idle.idx", 8'(idx0), 8'h00);
    end

    // reset in the middle of a grant, pointer must return to 7
    req = 8'h04; cyc();
    chk("mid.gnt", gnt0, 8'h04);
    rst_n = 1'b0; cyc();
    chk("mid.rstgnt", gnt0, 8'h00);
    chk("mid.rstvld", 8'(vld0), 8'h00);
    rst_n = 1'b1; req = 8'hFF; cyc();
    chk("mid.ffidx", 8'(idx0), 8'h00);

    // zero-bubble handoff
    do_reset();
    req = 8'h81; cyc();
    chk("hand.gnt0", gnt0, 8'h01);
    req = 8'h80; cyc();
    chk("hand.gnt7", gnt0, 8'h80);
    chk("hand.idx7", 8'(idx0), 8'h07);

    // fairness: each holder keeps 2 cycles then drops for one edge
    do_reset();
    req = 8'hFF; cyc();
    for (int k = 0; k < 9; k++) begin
      chk("fair.idx", 8'(idx0), 8'(k % 8));
      cyc();
      req = 8'hFF & ~(8'h01 << (k % 8));
      cyc();
      req = 8'hFF;
    end

    // MAX_HOLD=4 ping-pong between 0 and 3
    do_reset();
    req = 8'h09; cyc();
    chk("mh.a", gnt4, 8'h01);
    for (int i = 0; i < 3; i++) begin cyc(); chk("mh.hold0", gnt4, 8'h01); end
    cyc();
    chk("mh.b", gnt4, 8'h08);
    chk("mh.bpre", 8'(pre4), 8'h01);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("mh.hold3", gnt4, 8'h08); chk("mh.nopre", 8'(pre4), 8'h00);
    end
    cyc();
    chk("mh.c", gnt4, 8'h01);
    chk("mh.cpre", 8'(pre4), 8'h01);

    // limit reached with no competitor, then competitor appears
    do_reset();
    req = 8'h20;
    for (int i = 0; i < 20; i++) begin
      cyc(); chk("sat.gnt", gnt4, 8'h20); chk("sat.pre", 8'(pre4), 8'h00);
    end
    req = 8'h22; cyc();
    chk("sat.new", gnt4, 8'h02);
    chk("sat.pre1", 8'(pre4), 8'h01);

    // release with nothing pending, then wrap search from 5
    do_reset();
    req = 8'h10; cyc();
    chk("rel.gnt", gnt0, 8'h10);
    req = 8'h00; cyc();
    chk("rel.gnt0", gnt0, 8'h00);
    chk("rel.vld", 8'(vld0), 8'h00);
    chk("rel.idx", 8'(idx0), 8'h04);
    req = 8'h11; cyc();
    chk("rel.wrap", 8'(idx0), 8'h00);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      req   = 8'($urandom);
      if ($urandom_range(0, 1) == 1) req &= 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = (gnt0 | gnt4) | 8'($urandom_range(0, 1) << $urandom_range(0, 7));
      rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bank_grant_encoder8.md
Name: bank_grant_encoder8

Overview:
- Sequential 8-way round-robin arbiter with one-hot-to-binary encoding.
- It is the inverse of the RAM16K 1-to-8 bank-select decoder. Eight bank requesters raise one-hot requests; the block grants exactly one requester.
- It emits both a one-hot grant and a 3-bit bank index. The index feeds the RAM16K select / read-data mux.
- It enforces fairness and an optional maximum-hold limit.

Parameters:
- N, 8: number of requesters. Fixed at 8; the index width is 3.
- MAX_HOLD, 0: maximum consecutive cycles one requester may hold the grant while others wait. 0 means unlimited. Legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req  input  8  request vector; bit i = requester i wants the bank path
- gnt  output  8  one-hot grant (all zero when idle); registered
- gnt_idx  output  3  binary index of the granted requester; registered
- gnt_valid  output  1  high when gnt is non-zero; registered
- preempt  output  1  one-cycle pulse on the cycle a grant change was forced by MAX_HOLD

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, preempt=0.
  - State=IDLE, last pointer=3'd7 (so requester 0 has first priority), hold counter=0.
  - Reset mid-grant drops the grant immediately on that edge. No state survives.
- Priority search: starting from last+1 and wrapping modulo 8, the first index with req=1 wins. The search excludes the current holder where noted below.
- IDLE state:
  - If req != 0: on the next edge, grant the search winner.
    - gnt=one-hot(winner), gnt_idx=winner, gnt_valid=1, hold counter=0, state=BUSY.
  - Latency is 1 cycle from req sampled high to gnt visible.
  - If req=0: remain IDLE with outputs zero.
- BUSY state, holder h = gnt_idx:
  - Release (req[h]=0 at an edge): last←h.
    - If any other request is pending, grant the new search winner on the same edge (zero-bubble handoff). Hold counter=0.
    - Otherwise go IDLE: gnt=0, gnt_valid=0, gnt_idx keeps its last value.
  - Hold (req[h]=1, no preemption): outputs unchanged. Hold counter increments, saturating at 255.
  - Preemption: applies only when MAX_HOLD≠0, hold counter = MAX_HOLD-1, req[h]=1, and some other req bit is set.
    - last←h; grant the search winner excluding h. Hold counter=0. preempt=1 for exactly that cycle.
  - Limit reached with no other request: h keeps the grant and the counter saturates. Preemption happens the first cycle another request appears.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt == 1<<gnt_idx.
  - A requester with req=0 is never newly granted.
- Simultaneous events:
  - Requests arriving on the same edge as a release are included in the search.
  - The releasing requester cannot be re-granted on its own release edge.
- req bits may change arbitrarily and are sampled only at clock edges. No combinational path from req to any output.

Decomposition:
- Shared package holds:
  - the N and index-width constants;
  - the state encoding (IDLE=1'b0, BUSY=1'b1);
  - an onehot-to-index function, reused by RAM16K read-side logic.
- One natural sub-module: rr_pick8. It is purely combinational. Inputs: req[7:0], last[2:0], exclude-mask[7:0]. Outputs: found, winner[2:0]. It implements the circular priority search.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_valid=0, gnt_idx=0 throughout. Then assert rst_n=0 while gnt=8'h04 -> next edge gnt=8'h00, and the pointer returns so that a subsequent req=8'hFF grants index 0.
- From reset, req=8'h81 -> one cycle later gnt=8'h01, gnt_idx=0. Drop req[0] -> same edge gnt=8'h80, gnt_idx=7, no idle cycle.
- Round-robin fairness: req=8'hFF held; each granted requester drops for one edge after 2 cycles of grant -> grant order 0,1,2,…,7,0. No index is skipped or repeated.
- MAX_HOLD=4, req=8'h09 constantly -> idx 0 holds 4 cycles; then gnt=8'h08 with preempt=1 for one cycle; idx 3 holds 4 cycles; then back to idx 0.
- MAX_HOLD=4, only req[5]=1 for 20 cycles -> gnt=8'h20 for all 20 cycles, preempt never asserts. Raise req[1] at cycle 20 -> next edge gnt=8'h02, preempt=1.
- Release with nothing pending: gnt=8'h10, req→8'h00 -> next edge gnt=0, gnt_valid=0, gnt_idx stays 4. Then req=8'h11 -> grant idx 0 (search starts at 5 and wraps: 5,6,7,0).
